adder_bist_engine: RTL and testbench

//  Parametrised BIST engine for a WIDTH-bit adder CUT (successor to the 1-bit full-adder BIST).

---
 rtl/adder_bist_engine.sv | 142 ++++++++++++++
 tb/tb_adder_bist_engine.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_bist_engine.sv
// Built-in self-test engine for a WIDTH-bit adder circuit under test.
// An LFSR, extended by a single all-zero vector, walks every {a,b,cin}
// combination once per run. Each response is checked against a golden
// a+b+cin in the same cycle. Results are a sticky fault flag, a
// saturating fail count, the first failing vector and its index.
module adder_bist_engine #(
    parameter int              WIDTH = 4,
    parameter logic [2*WIDTH:0] POLY = 9'h110,
    parameter logic [2*WIDTH:0] SEED = 9'h001,
    parameter int              CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop_on_fail,
    output logic [WIDTH-1:0]     cut_a,
    output logic [WIDTH-1:0]     cut_b,
    output logic                 cut_cin,
    input  logic [WIDTH-1:0]     cut_sum,
    input  logic                 cut_cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 fault,
    output logic [CNT_W-1:0]     fail_count,
    output logic [2*WIDTH:0]     first_fail_pattern,
    output logic [2*WIDTH:0]     first_fail_index,
    output logic [2*WIDTH:0]     pattern_index
);

    localparam int PW = 2*WIDTH+1;
    localparam logic [PW-1:0] LAST_IDX = '1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    lfsr_q, lfsr_d;
    logic [PW-1:0]    idx_q, idx_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    ff_pat_q, ff_pat_d;
    logic [PW-1:0]    ff_idx_q, ff_idx_d;

    logic             running;
    logic [PW-1:0]    pattern;
    logic [PW-1:0]    cut_vec;
    logic [WIDTH:0]   exp_sum;
    logic             mismatch;

    assign running = (state_q == ST_RUN);

    // Current vector: LFSR state, except the final index, which substitutes
    // the all-zero vector an LFSR can never produce. Check it in the same cycle.
    always_comb begin
        pattern  = (idx_q == LAST_IDX) ? '0 : lfsr_q;
        cut_vec  = running ? pattern : '0;
        exp_sum  = {1'b0, cut_vec[PW-1:WIDTH+1]} + {1'b0, cut_vec[WIDTH:1]}
                 + {{WIDTH{1'b0}}, cut_vec[0]};
        mismatch = running && ({cut_cout, cut_sum} != exp_sum);
    end

    assign cut_a   = cut_vec[PW-1:WIDTH+1];
    assign cut_b   = cut_vec[WIDTH:1];
    assign cut_cin = cut_vec[0];

    // Run control: start clears results; each RUN cycle records the check
    // and either advances to the next vector or finishes the run.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        idx_d    = idx_q;
        fault_d  = fault_q;
        cnt_d    = cnt_q;
        ff_pat_d = ff_pat_q;
        ff_idx_d = ff_idx_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    lfsr_d   = SEED;
                    idx_d    = '0;
                    fault_d  = 1'b0;
                    cnt_d    = '0;
                    ff_pat_d = '0;
                    ff_idx_d = '0;
                end
            end
            ST_RUN: begin
                if (mismatch) begin
                    fault_d = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (!fault_q) begin
                        ff_pat_d = pattern;
                        ff_idx_d = idx_q;
                    end
                end
                if ((idx_q == LAST_IDX) || (mismatch && stop_on_fail)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d  = idx_q + 1'b1;
                    lfsr_d = {lfsr_q[PW-2:0], ^(lfsr_q & POLY)};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and result registers; reset aborts any run and discards results.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= SEED;
            idx_q    <= '0;
            fault_q  <= 1'b0;
            cnt_q    <= '0;
            ff_pat_q <= '0;
            ff_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            idx_q    <= idx_d;
            fault_q  <= fault_d;
            cnt_q    <= cnt_d;
            ff_pat_q <= ff_pat_d;
            ff_idx_q <= ff_idx_d;
        end
    end

    assign busy               = running;
    assign done               = (state_q == ST_DONE);
    assign pass               = done && !fault_q;
    assign fault              = fault_q;
    assign fail_count         = cnt_q;
    assign first_fail_pattern = ff_pat_q;
    assign first_fail_index   = ff_idx_q;
    assign pattern_index      = idx_q;

endmodule

// File: tb/tb_adder_bist_engine.sv
// Bench for adder_bist_engine: a behavioural adder with selectable faults
// stands in for the CUT, and a vector-list model predicts every run result.
module tb_adder_bist_engine;

    localparam int WIDTH = 4;
    localparam int PW    = 2*WIDTH+1;
    localparam int NUM   = 1 << PW;
    localparam logic [PW-1:0] POLY = 9'h110;
    localparam logic [PW-1:0] SEED = 9'h001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic stop_on_fail = 1'b0;
    int   fault_mode = 0;
    int   fault_key = 0;

    logic [WIDTH-1:0] cut_a, cut_b, cut_sum;
    logic             cut_cin, cut_cout;
    logic             busy, done, pass, fault;
    logic [15:0]      fail_count;
    logic [PW-1:0]    first_fail_pattern, first_fail_index, pattern_index;

    logic [WIDTH-1:0] s_a, s_b, s_sum;
    logic             s_cin, s_cout, s_busy, s_done, s_pass, s_fault;
    logic [3:0]       s_fail_count;
    logic [PW-1:0]    s_ffp, s_ffi, s_pidx;

    always #5 clk = ~clk;

    // Adder with optional fault: 1 sum[0] SA0, 2 cout SA1,
    // 3 keyed sparse bit flip, 4 wrong answer only for all-zero inputs.
    function automatic logic [WIDTH:0] cut_fn(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b,
                                              logic cin, int mode, int key);
        logic [WIDTH:0] r;
        int p;
        r = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        p = int'({a, b, cin});
        case (mode)
            1: r[0] = 1'b0;
            2: r[WIDTH] = 1'b1;
            3: if ((p * 7 + key) % 13 == 0) r[key % WIDTH] = ~r[key % WIDTH];
            4: if (p == 0) r[0] = 1'b1;
            default: ;
        endcase
        return r;
    endfunction

    assign {cut_cout, cut_sum} = cut_fn(cut_a, cut_b, cut_cin, fault_mode, fault_key);
    assign {s_cout, s_sum}     = cut_fn(s_a, s_b, s_cin, 1, 0);

    adder_bist_engine u_dut (
        .clk(clk), .rst(rst), .start(start), .stop_on_fail(stop_on_fail),
        .cut_a(cut_a), .cut_b(cut_b), .cut_cin(cut_cin),
        .cut_sum(cut_sum), .cut_cout(cut_cout),
        .busy(busy), .done(done), .pass(pass), .fault(fault),
        .fail_count(fail_count), .first_fail_pattern(first_fail_pattern),
        .first_fail_index(first_fail_index), .pattern_index(pattern_index)
    );

    adder_bist_engine #(.CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .start(start), .stop_on_fail(stop_on_fail),
        .cut_a(s_a), .cut_b(s_b), .cut_cin(s_cin),
        .cut_sum(s_sum), .cut_cout(s_cout),
        .busy(s_busy), .done(s_done), .pass(s_pass), .fault(s_fault),
        .fail_count(s_fail_count), .first_fail_pattern(s_ffp),
        .first_fail_index(s_ffi), .pattern_index(s_pidx)
    );

    typedef struct {
        int mode; int key; bit stop; bit hold;
        int exp_busy; bit exp_pass; int exp_fails;
        int exp_ffi; int exp_ffp; int exp_pidx;
    } vec_t;

    logic [PW-1:0] pats [NUM];
    vec_t tbl [10];
    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Predict a whole run by walking the vector list in order.
    function automatic vec_t model(vec_t v);
        logic [WIDTH:0] good, resp;
        logic [PW-1:0] p;
        bit mm;
        v.exp_fails = 0; v.exp_ffi = 0; v.exp_ffp = 0; v.exp_pidx = NUM-1;
        for (int i = 0; i < NUM; i++) begin
            p    = pats[i];
            good = {1'b0, p[PW-1:WIDTH+1]} + {1'b0, p[WIDTH:1]} + {{WIDTH{1'b0}}, p[0]};
            resp = cut_fn(p[PW-1:WIDTH+1], p[WIDTH:1], p[0], v.mode, v.key);
            mm   = (resp != good);
            if (mm) begin
                if (v.exp_fails == 0) begin v.exp_ffi = i; v.exp_ffp = int'(p); end
                v.exp_fails++;
                if (v.stop) begin v.exp_pidx = i; break; end
            end
        end
        v.exp_busy = v.exp_pidx + 1;
        v.exp_pass = (v.exp_fails == 0);
        return v;
    endfunction

    task automatic run_case(input vec_t v, input string tag);
        int n;
        int verr;
        fault_mode   = v.mode;
        fault_key    = v.key;
        stop_on_fail = v.stop;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!v.hold) start = 1'b0;
        chk({tag, " cleared"}, {busy, fault, 16'(fail_count), first_fail_index},
            {1'b1, 1'b0, 16'd0, 9'd0});
        n = 0; verr = 0;
        while (busy && n < NUM + 50) begin
            if (n < NUM) begin
                if ({cut_a, cut_b, cut_cin} !== pats[n] || pattern_index !== PW'(n)) verr++;
            end
            n++;
            @(negedge clk);
        end
        chk({tag, " busy_cycles"}, n, v.exp_busy);
        chk({tag, " vector_seq"}, verr, 0);
        chk({tag, " done"}, done, 1);
        chk({tag, " pass"}, pass, v.exp_pass);
        chk({tag, " fault"}, fault, !v.exp_pass);
        chk({tag, " fail_count"}, fail_count, v.exp_fails);
        chk({tag, " first_fail_index"}, first_fail_index, v.exp_ffi);
        chk({tag, " first_fail_pattern"}, first_fail_pattern, v.exp_ffp);
        chk({tag, " pattern_index"}, pattern_index, v.exp_pidx);
        chk({tag, " cut_idle"}, {cut_a, cut_b, cut_cin}, 0);
        chk({tag, " sat_count"}, s_fail_count, v.stop ? 1 : 15);
        if (v.hold) begin
            @(negedge clk);
            chk({tag, " restart_from_done"}, {busy, pattern_index}, {1'b1, 9'd0});
            start = 1'b0;
            n = 0;
            while (!done && n < NUM + 50) begin n++; @(negedge clk); end
            chk({tag, " second_run_done"}, {done, pass, pattern_index}, {1'b1, 1'b1, 9'd511});
        end
    endtask

    initial begin
        logic [PW-1:0] l;
        vec_t v;
        int n;

        l = SEED;
        for (int i = 0; i < NUM; i++) begin
            pats[i] = (i == NUM-1) ? '0 : l;
            l = {l[PW-2:0], ^(l & POLY)};
        end

        //              mode key stop hold busy pass fails ffi ffp pidx
        tbl[0] = '{0, 0, 0, 0, 512, 1, 0,   0,   0,     511};
        tbl[1] = '{1, 0, 0, 0, 512, 0, 256, 0,   1,     511};
        tbl[2] = '{1, 0, 1, 0, 1,   0, 1,   0,   1,     0};
        tbl[3] = model('{2, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl[3].exp_fails = 256;
        tbl[4] = '{4, 0, 1, 0, 512, 0, 1,   511, 0,     511};
        tbl[5] = '{0, 0, 0, 1, 512, 1, 0,   0,   0,     511};
        for (int i = 6; i < 10; i++) begin
            v = '{3, int'($urandom_range(0, 999)), bit'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 0, 0};
            tbl[i] = model(v);
        end

        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, pass, fault, fail_count, first_fail_pattern,
                              first_fail_index, pattern_index, cut_a, cut_b, cut_cin}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {busy, done, cut_a, cut_b, cut_cin}, 0);

        for (int i = 0; i < 10; i++) run_case(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of a run.
        fault_mode = 0; stop_on_fail = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (pattern_index != 9'd100 && n < NUM) begin n++; @(negedge clk); end
        chk("reached_index_100", {busy, pattern_index}, {1'b1, 9'd100});
        rst = 1'b0;
        #1;
        chk("abort_outputs", {busy, done, pass, fault, fail_count, first_fail_pattern,
                              first_fail_index, pattern_index, cut_a, cut_b, cut_cin}, 0);
        @(negedge clk); rst = 1'b1;
        run_case(tbl[0], "after_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
